// File: rtl/shreg_pkg.sv
// Shared encodings for the burst shift register controller.
// Build option: define SHREG_ROTATE_EN to enable the rotl/rotr modes.
package shreg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    SHL   = 3'b000,
    SHR   = 3'b001,
    LOAD  = 3'b010,
    CLEAR = 3'b011,
    ROTL  = 3'b100,
    ROTR  = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True for modes that run a counted burst of steps in this build.
  function automatic logic is_burst(input logic [MODE_W-1:0] mode);
`ifdef SHREG_ROTATE_EN
    return (mode == SHL) || (mode == SHR) || (mode == ROTL) || (mode == ROTR);
`else
    return (mode == SHL) || (mode == SHR);
`endif
  endfunction

endpackage

// File: rtl/shreg_core.sv
// WIDTH*DEPTH storage with one-word shift/rotate, parallel load and clear.
// Build option: SHREG_ROTATE_EN adds the rotate input and feedback mux.
module shreg_core #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_i,
  input  logic                   dir_i,
`ifdef SHREG_ROTATE_EN
  input  logic                   rot_i,
`endif
  input  logic                   load_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic [WIDTH*DEPTH-1:0] pdata_i,
  output logic [WIDTH*DEPTH-1:0] pdata_o,
  output logic [WIDTH-1:0]       out_word_o
);

  logic [WIDTH*DEPTH-1:0] data_q, data_d;
  logic [WIDTH-1:0]       in_word;

  // dir_i=0 moves words toward the top index, so the top word leaves.
  assign out_word_o = dir_i ? data_q[WIDTH-1:0] : data_q[WIDTH*DEPTH-1 -: WIDTH];

`ifdef SHREG_ROTATE_EN
  assign in_word = rot_i ? out_word_o : din_i;
`else
  assign in_word = din_i;
`endif

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (load_i) begin
      data_d = pdata_i;
    end else if (step_i) begin
      if (dir_i) begin
        data_d = {in_word, data_q[WIDTH*DEPTH-1:WIDTH]};
      end else begin
        data_d = {data_q[WIDTH*(DEPTH-1)-1:0], in_word};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign pdata_o = data_q;

endmodule

// File: rtl/shift_register_ctrl.sv
// Command-driven burst shift register: handshake, step counter and flags.
// Build option: SHREG_ROTATE_EN enables modes 100/101 (otherwise illegal).
module shift_register_ctrl
  import shreg_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int DEPTH   = 256,
  parameter int COUNT_W = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [MODE_W-1:0]      cmd_mode_i,
  input  logic [COUNT_W-1:0]     cmd_count_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   din_valid_i,
  input  logic [WIDTH*DEPTH-1:0] pdata_in_i,
  output logic [WIDTH*DEPTH-1:0] pdata_out_o,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   dout_valid_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cmd_err_o
);

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               step, load, clear, step_en;
  logic [WIDTH-1:0]   out_word;

`ifdef SHREG_ROTATE_EN
  logic rot_q, rot_d;
  assign step_en = din_valid_i || rot_q;
`else
  assign step_en = din_valid_i;
`endif

  // Only the decoded direction/rotate bits are kept; legality is resolved at accept.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    count_d      = count_q;
    err_d        = err_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    step         = 1'b0;
    load         = 1'b0;
    clear        = 1'b0;
`ifdef SHREG_ROTATE_EN
    rot_d        = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          dir_d   = cmd_mode_i[0];
`ifdef SHREG_ROTATE_EN
          rot_d   = cmd_mode_i[2];
`endif
          count_d = cmd_count_i;
          err_d   = 1'b0;
          state_d = DONE;
          if (is_burst(cmd_mode_i)) begin
            if (cmd_count_i != '0) state_d = SHIFT;
          end else if (cmd_mode_i == LOAD) begin
            load = 1'b1;
          end else if (cmd_mode_i == CLEAR) begin
            clear = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (step_en) begin
          step         = 1'b1;
          dout_d       = out_word;
          dout_valid_d = 1'b1;
          count_d      = count_q - COUNT_W'(1);
          if (count_q == COUNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      count_q      <= '0;
      err_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef SHREG_ROTATE_EN
      rot_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      count_q      <= count_d;
      err_q        <= err_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef SHREG_ROTATE_EN
      rot_q        <= rot_d;
`endif
    end
  end

  shreg_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_i     (step),
    .dir_i      (dir_q),
`ifdef SHREG_ROTATE_EN
    .rot_i      (rot_q),
`endif
    .load_i     (load),
    .clear_i    (clear),
    .din_i      (din_i),
    .pdata_i    (pdata_in_i),
    .pdata_o    (pdata_out_o),
    .out_word_o (out_word)
  );

  assign cmd_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign cmd_err_o    = (state_q == DONE) && err_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;

endmodule

// File: doc/shift_register_ctrl.md
Name: shift_register_ctrl

Overview:
- Parametrised successor to the fixed 256-bit serial shift register.
- Holds DEPTH words of WIDTH bits each.
- A command handshake starts a burst of N shifts in either direction. Parallel load and clear are also available as commands.
- Sits between the serial datapath and the control sequencer, which now issues burst commands instead of holding enable for N cycles.

Parameters:
- WIDTH, 1, bits per word (lane width).
- DEPTH, 256, number of word stages; minimum 2.
- COUNT_W, 9, width of cmd_count; must satisfy 2**COUNT_W > DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_mode  in  3  000 shl, 001 shr, 010 load, 011 clear, 100 rotl, 101 rotr, 110/111 illegal
- cmd_count  in  COUNT_W  number of shifts in the burst (shift and rotate modes only)
- din  in  WIDTH  serial word in
- din_valid  in  1  din qualifier; a shift advances only when high
- pdata_in  in  WIDTH*DEPTH  parallel load data; word 0 = bits [WIDTH-1:0]
- pdata_out  out  WIDTH*DEPTH  current register contents
- dout  out  WIDTH  word shifted or rotated out
- dout_valid  out  1  one-cycle qualifier on dout
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse at the end of every accepted command
- cmd_err  out  1  pulses with done for an illegal (or disabled) mode

Behaviour:
- Reset: register all zero. State IDLE. cmd_ready=1; dout=0; dout_valid=0; busy=0; done=0; cmd_err=0. Reset mid-burst aborts the burst immediately; no done pulse.
- FSM states are IDLE, SHIFT and DONE. cmd_ready=1 only in IDLE.
- IDLE: on accept, mode and count are latched.
  - Shift or rotate with count>0: go to SHIFT.
  - Shift or rotate with count==0: go to DONE, no data change.
  - Load: pdata_in is captured on the accept edge, then DONE.
  - Clear: register is zeroed on the accept edge, then DONE.
  - Illegal mode: DONE with cmd_err; data unchanged.
- SHIFT, per-cycle step:
  - A shl/shr step occurs on a cycle with din_valid=1. Cycles with din_valid=0 stall with no change and dout_valid=0.
  - Rotl/rotr step every cycle; din and din_valid are ignored.
  - Step shl: word[i] <= word[i-1]; word[0] <= din; dout <= old word[DEPTH-1].
  - Step shr: word[i] <= word[i+1]; word[DEPTH-1] <= din; dout <= old word[0].
  - Step rotl/rotr: same movement, but the outgoing word re-enters the vacated end; dout <= outgoing word.
  - dout_valid=1 in the cycle after each step edge (registered output).
  - A remaining-count register decrements per step. On the edge of the last step, go to DONE.
- DONE: lasts one cycle. done=1, plus cmd_err if the mode was illegal; then IDLE.
  - Minimum command-to-command spacing is therefore 2 cycles for load/clear and count+2 for bursts with no stalls.
- dout holds its last value when dout_valid=0.
- Counts greater than DEPTH are legal: the shift continues and the contents wrap naturally (a rotate of DEPTH steps restores the original).
- cmd_valid while busy is ignored; the requester holds it until cmd_ready.
- pdata_out is combinational from the register and reflects each edge immediately.

Optional Feature:
- Macro: SHREG_ROTATE_EN.
- Defined: modes 100/101 perform rotl/rotr as above.
- Undefined:
  - Modes 100/101 are illegal: DONE with cmd_err=1 and no data change.
  - The rotate datapath mux is not synthesised.

Decomposition:
- Package shreg_pkg holds:
  - mode encodings as a 3-bit enum: SHL, SHR, LOAD, CLEAR, ROTL, ROTR;
  - FSM state enum: IDLE, SHIFT, DONE;
  - the shared mode-width constant.
- Sub-module shreg_core holds:
  - the WIDTH*DEPTH storage;
  - inputs step, dir, rot, load, clear;
  - outputs pdata_out and the outgoing word.
- The top level holds the FSM, the counter and the handshake/flag registers.

Test Plan:
- Reset then shl, count=4, WIDTH=8, DEPTH=4, din stream 0x11,0x22,0x33,0x44 with din_valid=1 -> dout_valid four times with dout=0x00 each; pdata_out=0x11223344; done one cycle after the fourth step.
- Load pdata_in=0xA1B2C3D4, then shr count=2 with din=0xEE,0xFF -> dout=0xD4 then 0xC3; pdata_out=0xFFEEA1B2.
- Load 0x01020304, then rotl count=4 (SHREG_ROTATE_EN defined) -> dout=0x01,0x02,0x03,0x04; final pdata_out=0x01020304.
- Same command with the macro undefined -> done and cmd_err pulse after 1 cycle; pdata_out unchanged.
- Shl count=3 with din_valid toggling 1,0,0,1,1 -> exactly 3 steps over 5 cycles; no dout_valid on stall cycles.
- Count=0 command -> done 1 cycle after accept with data unchanged.
- Reset asserted mid-burst -> all outputs return to reset values; no done pulse; cmd_ready=1 after reset release.
